pu_or1k_spr_arbiter: RTL
========================

# pu_or1k_spr_arbiter

Sequences all special-purpose-register accesses for the PU-OR1K core. Arbitrates between the pipeline control stage (mfspr/mtspr) and the debug unit. Serves group-0 configuration registers (VR, UPR, CPUCFGR, ..., AVR) locally from the configuration-register block outputs, and forwards every other SPR access to the shared SPR bus with a bounded-wait timeout.

## Interface

Parameters:
- OPTION_SPR_TIMEOUT, 16: maximum number of cycles a bus access may wait for `spr_bus_ack_i` (range 1-255).
- FEATURE_DEBUGUNIT, "NONE": when "NONE", the debug port is ignored; `du_spr_ack_o` and `du_spr_err_o` are tied 0.

Ports. Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset

CPU requester (the debug port mirrors it with the `du_` prefix):
- cpu_spr_req_i  in  1  access request; held stable until ack
- cpu_spr_we_i  in  1  1 = mtspr, 0 = mfspr
- cpu_spr_addr_i  in  16  SPR address {group[15:11], index[10:0]}
- cpu_spr_dat_i  in  32  write data
- cpu_spr_ack_o  out  1  one-cycle completion pulse
- cpu_spr_err_o  out  1  valid with ack; access failed
- cpu_spr_dat_o  out  32  read data, valid with ack
- du_spr_req_i, du_spr_we_i, du_spr_addr_i, du_spr_dat_i, du_spr_ack_o, du_spr_err_o, du_spr_dat_o: same directions and widths as above

Configuration inputs (static):
- spr_vr_i, spr_upr_i, spr_cpucfgr_i, spr_dmmucfgr_i, spr_immucfgr_i, spr_dccfgr_i, spr_iccfgr_i, spr_dcfgr_i, spr_pccfgr_i, spr_vr2_i, spr_avr_i  in  32 each

Shared SPR bus:
- spr_bus_stb_o  out  1  access strobe
- spr_bus_we_o  out  1  write enable
- spr_bus_addr_o  out  16  address
- spr_bus_dat_o  out  32  write data
- spr_bus_ack_i  in  1  slave completion
- spr_bus_dat_i  in  32  slave read data

## Operation

FSM states: IDLE, CFG, BUS, RESP.

IDLE:
- Samples requests.
- One requester high: grant it.
- Both high: grant the one not granted last (round-robin, tracked by a `last_grant` bit).
- On grant: latch we/addr/dat and the grant owner.
- Next state is CFG if group == 0 and index <= 10, else BUS.

CFG:
- Read index map: 0 VR, 1 UPR, 2 CPUCFGR, 3 DMMUCFGR, 4 IMMUCFGR, 5 DCCFGR, 6 ICCFGR, 7 DCFGR, 8 PCCFGR, 9 VR2, 10 AVR.
- Read: register the selected value into the owner's dat_o with err = 0.
- Write: the write is discarded, with dat_o = 0 and err = 1.
- Next state: RESP.

BUS:
- stb/we/addr/dat are driven from the latches; stb is high for the whole state.
- On `spr_bus_ack_i`: capture `spr_bus_dat_i` (reads; writes return 0), err = 0, go to RESP.
- A timeout counter increments each BUS cycle. When the counter equals OPTION_SPR_TIMEOUT with no ack: drop stb, err = 1, dat = 0, go to RESP.
- Counter is cleared on BUS entry; width is 8 bits.

RESP:
- Owner's ack_o is high for exactly this cycle; the non-owner's ack stays 0.
- Next state: IDLE.

Requester and boundary rules:
- A requester must deassert req in the cycle after its ack. A registered requester does this naturally; otherwise it is re-granted as a new access.
- `spr_bus_ack_i` outside BUS, including a late ack after timeout, is ignored.
- Group-0 indices above 10 (SR, EPCR, ...) are forwarded to the bus.
- FEATURE_DEBUGUNIT == "NONE": du_req is treated as 0.

## Timing

Reset (asynchronous, any state, including mid-bus-access):
- state = IDLE; all ack/err/stb/we outputs = 0; all dat/addr outputs = 0.
- Counter = 0; `last_grant` = DU, so the CPU wins the first tie.
- An in-flight access is abandoned with no ack.

Latency, with req first seen high in IDLE at cycle 0:
- Config access: ack at cycle 2.
- Bus access: stb high from cycle 1. If `spr_bus_ack_i` arrives in cycle k (k >= 1), stb drops after cycle k and the requester ack is at cycle k+1.
- Timeout: stb high in cycles 1..OPTION_SPR_TIMEOUT; ack with err = 1 at cycle OPTION_SPR_TIMEOUT+1.
- Throughput: one access in flight. Back-to-back grants occur at most every 3 cycles (config path).

Output timing: all requester outputs are registered; bus outputs are registered.

## Test plan

1. CPU reads addr 0x0002 with spr_cpucfgr_i = 0x0000_0720 -> cpu_spr_ack_o = 1 at cycle 2, cpu_spr_dat_o = 0x0000_0720, err = 0; spr_bus_stb_o stays 0.
2. CPU writes addr 0x0000 (VR), data 0xDEAD_BEEF -> ack at cycle 2, err = 1, dat_o = 0; no bus strobe.
3. CPU reads addr 0x0011 (SR); slave acks in cycle 3 with 0x0000_8001 -> stb high in cycles 1-3, addr_o = 0x0011, we_o = 0; cpu_spr_dat_o = 0x0000_8001 with ack at cycle 4.
4. DU reads addr 0x2800 with no slave ack, OPTION_SPR_TIMEOUT = 16 -> stb high in cycles 1-16, du_spr_ack_o with err = 1 and dat = 0 at cycle 17. A late `spr_bus_ack_i` at cycle 18 causes no output.
5. CPU and DU both request config reads in cycle 0 -> CPU acked at cycle 2. The DU is granted in the IDLE cycle 3 and acked at cycle 5. Repeating with both still requesting alternates the grants DU, CPU.
6. Assert rst in cycle 2 of a bus access -> stb, ack and err go to 0 immediately, state is IDLE. After rst falls, a new CPU read completes normally.

Source files
------------

// File: rtl/pu_or1k_spr_arbiter.sv
// SPR access sequencer: arbitrates CPU and debug-unit requests round-robin, serves group-0
// configuration registers locally and forwards all other SPRs to the shared bus with a timeout.
module pu_or1k_spr_arbiter #(
  parameter int    OPTION_SPR_TIMEOUT = 16,
  parameter string FEATURE_DEBUGUNIT  = "NONE"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_spr_req_i,
  input  logic        cpu_spr_we_i,
  input  logic [15:0] cpu_spr_addr_i,
  input  logic [31:0] cpu_spr_dat_i,
  output logic        cpu_spr_ack_o,
  output logic        cpu_spr_err_o,
  output logic [31:0] cpu_spr_dat_o,
  input  logic        du_spr_req_i,
  input  logic        du_spr_we_i,
  input  logic [15:0] du_spr_addr_i,
  input  logic [31:0] du_spr_dat_i,
  output logic        du_spr_ack_o,
  output logic        du_spr_err_o,
  output logic [31:0] du_spr_dat_o,
  input  logic [31:0] spr_vr_i,
  input  logic [31:0] spr_upr_i,
  input  logic [31:0] spr_cpucfgr_i,
  input  logic [31:0] spr_dmmucfgr_i,
  input  logic [31:0] spr_immucfgr_i,
  input  logic [31:0] spr_dccfgr_i,
  input  logic [31:0] spr_iccfgr_i,
  input  logic [31:0] spr_dcfgr_i,
  input  logic [31:0] spr_pccfgr_i,
  input  logic [31:0] spr_vr2_i,
  input  logic [31:0] spr_avr_i,
  output logic        spr_bus_stb_o,
  output logic        spr_bus_we_o,
  output logic [15:0] spr_bus_addr_o,
  output logic [31:0] spr_bus_dat_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_bus_dat_i
);

  typedef enum logic [1:0] {IDLE, CFG, BUS, RESP} state_t;

  localparam logic DU_EN = (FEATURE_DEBUGUNIT != "NONE");

  state_t      state, state_nxt;
  logic        du_req, grant_cpu, grant_du, cfg_hit, bus_timeout;
  logic        owner_du, last_grant, we_q;
  logic [3:0]  cfg_idx;
  logic [7:0]  cnt;
  logic [15:0] req_addr;
  logic [31:0] req_dat, cfg_dat, resp_dat;
  logic        req_we, resp_err;
  logic        cpu_ack_q, cpu_err_q, du_ack_q, du_err_q;
  logic [31:0] cpu_dat_q, du_dat_q;

  // last_grant = 1 means the DU won the previous grant, so the CPU wins the next tie
  assign du_req    = DU_EN & du_spr_req_i;
  assign grant_du  = (state == IDLE) & du_req & (~cpu_spr_req_i | ~last_grant);
  assign grant_cpu = (state == IDLE) & cpu_spr_req_i & ~grant_du;
  assign req_addr  = grant_du ? du_spr_addr_i : cpu_spr_addr_i;
  assign req_dat   = grant_du ? du_spr_dat_i  : cpu_spr_dat_i;
  assign req_we    = grant_du ? du_spr_we_i   : cpu_spr_we_i;
  assign cfg_hit   = (req_addr[15:11] == 5'd0) && (req_addr[10:0] <= 11'd10);
  assign bus_timeout = ~spr_bus_ack_i && (({1'b0, cnt} + 9'd1) == 9'(OPTION_SPR_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_cpu || grant_du) state_nxt = cfg_hit ? CFG : BUS;
      CFG:     state_nxt = RESP;
      BUS:     if (spr_bus_ack_i || bus_timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (cfg_idx)
      4'd0:    cfg_dat = spr_vr_i;
      4'd1:    cfg_dat = spr_upr_i;
      4'd2:    cfg_dat = spr_cpucfgr_i;
      4'd3:    cfg_dat = spr_dmmucfgr_i;
      4'd4:    cfg_dat = spr_immucfgr_i;
      4'd5:    cfg_dat = spr_dccfgr_i;
      4'd6:    cfg_dat = spr_iccfgr_i;
      4'd7:    cfg_dat = spr_dcfgr_i;
      4'd8:    cfg_dat = spr_pccfgr_i;
      4'd9:    cfg_dat = spr_vr2_i;
      4'd10:   cfg_dat = spr_avr_i;
      default: cfg_dat = '0;
    endcase
  end

  // Only consulted on the cycle that enters RESP; a bus exit without ack is the timeout
  always_comb begin
    resp_err = 1'b0;
    resp_dat = '0;
    if (state == CFG) begin
      resp_err = we_q;
      resp_dat = we_q ? '0 : cfg_dat;
    end else if (spr_bus_ack_i) begin
      resp_dat = we_q ? '0 : spr_bus_dat_i;
    end else begin
      resp_err = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_du   <= 1'b0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      cfg_idx    <= '0;
      cnt        <= '0;
    end else begin
      if (grant_cpu || grant_du) begin
        owner_du   <= grant_du;
        last_grant <= grant_du;
        we_q       <= req_we;
        cfg_idx    <= req_addr[3:0];
      end
      cnt <= (state == BUS) ? cnt + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spr_bus_stb_o  <= 1'b0;
      spr_bus_we_o   <= 1'b0;
      spr_bus_addr_o <= '0;
      spr_bus_dat_o  <= '0;
    end else begin
      spr_bus_stb_o <= (state_nxt == BUS);
      if (state == IDLE && state_nxt == BUS) begin
        spr_bus_we_o   <= req_we;
        spr_bus_addr_o <= req_addr;
        spr_bus_dat_o  <= req_dat;
      end else if (state_nxt != BUS) begin
        spr_bus_we_o   <= 1'b0;
        spr_bus_addr_o <= '0;
        spr_bus_dat_o  <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ack_q <= 1'b0;
      cpu_err_q <= 1'b0;
      cpu_dat_q <= '0;
      du_ack_q  <= 1'b0;
      du_err_q  <= 1'b0;
      du_dat_q  <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      cpu_err_q <= 1'b0;
      du_ack_q  <= 1'b0;
      du_err_q  <= 1'b0;
      if (state_nxt == RESP && state != RESP) begin
        if (owner_du) begin
          du_ack_q  <= 1'b1;
          du_err_q  <= resp_err;
          du_dat_q  <= resp_dat;
        end else begin
          cpu_ack_q <= 1'b1;
          cpu_err_q <= resp_err;
          cpu_dat_q <= resp_dat;
        end
      end
    end
  end

  assign cpu_spr_ack_o = cpu_ack_q;
  assign cpu_spr_err_o = cpu_err_q;
  assign cpu_spr_dat_o = cpu_dat_q;
  assign du_spr_ack_o  = DU_EN & du_ack_q;
  assign du_spr_err_o  = DU_EN & du_err_q;
  assign du_spr_dat_o  = DU_EN ? du_dat_q : 32'd0;

endmodule
